mpif_tx_fifo_scheduler: RTL and testbench
=========================================

Name: mpif_tx_fifo_scheduler

Overview:
Round-robin write-side scheduler sharing one MPIF transmit FIFO write port between NREQ requesters.
- Grants one requester at a time for a burst of up to MAXBURST words, or until that requester's packet-last word.
- Throttles writes on fifoFull.
- Sequences FIFO flush: drives the flush request and waits for null pointers before returning to service.
- Sits in the write-clock domain, directly in front of the FIFO controller.

Parameters:
NREQ, 4, number of requesters (2..8)
DATAWIDTH, 32, FIFO word width
MAXBURST, 8, maximum words per grant (>=1)
FLUSH_CYCLES, 4, cycles fifoFlush is held high
FLUSH_TIMEOUT, 64, maximum cycles to wait for fifoPtrsNull after flush

Ports:
clk  in  1  single clock
hardReset  in  1  synchronous active-high reset
req  in  NREQ  per-requester word-valid
reqLast  in  NREQ  per-requester last word of packet
reqData  in  NREQ*DATAWIDTH  packed data, requester i at bits [i*DATAWIDTH +: DATAWIDTH]
reqAck  out  NREQ  word accepted this cycle, one-hot or zero
grant  out  NREQ  registered one-hot current owner
fifoWrite  out  1  FIFO write enable
fifoWrData  out  DATAWIDTH  FIFO write data
fifoFull  in  1  FIFO full
fifoPtrsNull  in  1  FIFO pointers null
flushReq  in  1  flush request, level, sampled each cycle
fifoFlush  out  1  flush to FIFO controller
flushDone  out  1  one-cycle pulse: flush sequence finished
flushTimeout  out  1  sticky: last flush ended on timeout; cleared by the next flushReq acceptance

Behaviour:
- Clock and reset: one clock `clk`; reset `hardReset` is synchronous and active-high. Reset applies only at a rising clk edge with hardReset=1.
- Reset values: state=IDLE, grant=0, lastGrant=NREQ-1 (so requester 0 wins first), burstCnt=0, flushCnt=0, fifoFlush=0, flushDone=0, flushTimeout=0. Combinational outputs evaluate to 0 in IDLE.
- IDLE:
  - flushReq=1 -> FLUSH. Flush has priority over any request.
  - Otherwise, if |req, grant the first requester with req=1 searching upward from lastGrant+1 mod NREQ. Register grant, burstCnt=0, -> XFER.
  - Arbitration latency is 1 cycle; no write occurs in IDLE.
- XFER, g = granted index:
  - accept = req[g] & ~fifoFull & ~flushReq
  - fifoWrite = accept; reqAck[g] = accept; fifoWrData = reqData[g] (combinational mux, valid whenever grant is nonzero).
  - On accept, burstCnt += 1 (width clog2(MAXBURST+1)).
  - End of burst on accept with reqLast[g]=1, or when burstCnt reaches MAXBURST-1. Then grant=0, lastGrant=g, -> IDLE.
  - req[g]=0 while granted: treated as abandonment. Same end-of-burst action, no write that cycle.
  - fifoFull=1 with req[g]=1: hold grant and state, no write, burstCnt unchanged. No timeout.
  - flushReq=1: abort immediately, no write that cycle, grant=0, lastGrant=g, -> FLUSH.
- FLUSH:
  - Clear flushTimeout.
  - Hold fifoFlush=1 for exactly FLUSH_CYCLES cycles using flushCnt, then fifoFlush=0, flushCnt=0, -> FWAIT.
- FWAIT:
  - fifoPtrsNull=1 -> flushDone=1 for one cycle, -> IDLE.
  - flushCnt reaching FLUSH_TIMEOUT-1 -> flushDone=1, flushTimeout=1, -> IDLE.
- flushReq still high on return to IDLE starts a new flush. flushReq is a level input, so the requester must drop it on seeing flushDone.
- Invariants:
  - fifoWrite is never high while fifoFull=1 or fifoFlush=1.
  - grant has at most one bit set.
  - reqAck is a subset of grant.
- hardReset mid-burst or mid-flush: next cycle is IDLE with reset values. Partial bursts are not resumed, and no flushDone is produced.

Decomposition:
- Shared package mpif_sched_pkg: state enum (IDLE, XFER, FLUSH, FWAIT), and the clog2 function for counter widths.
- One natural sub-module: mpif_rr_arbiter (NREQ one-hot rotating-priority search from lastGrant, purely combinational, reusable on the read side).

Test Plan:
1. Reset, then req=4'b0101, reqLast on 3rd word of each: grant=0001 one cycle after req; 3 fifoWrite pulses with requester-0 data; then grant=0100; 3 writes; lastGrant=2.
2. NREQ=4, MAXBURST=8, req[1] continuous, no reqLast: exactly 8 writes, grant drops for 1 IDLE cycle, requester 1 regranted only if no other req; with req[2] also high, grant moves to 0100.
3. fifoFull=1 for cycles 3-6 of a burst: fifoWrite=0 and reqAck=0 those cycles, grant held, burst completes with correct word count.
4. flushReq during XFER word 2: no write that cycle, fifoFlush high exactly 4 cycles, fifoPtrsNull asserted 3 cycles later, flushDone single pulse, flushTimeout=0.
5. Flush with fifoPtrsNull stuck 0: flushDone and flushTimeout=1 exactly 64 cycles after fifoFlush falls; next flushReq clears flushTimeout.
6. hardReset asserted mid-burst and mid-flush: next cycle grant=0, fifoFlush=0, fifoWrite=0, no flushDone; first arbitration after reset grants requester 0.

Source files
------------

// File: rtl/mpif_sched_pkg.sv
// Purpose: shared types and helpers for the MPIF FIFO write/read schedulers.
// Contents: scheduler state enum, clog2 helper for sizing counters and indices.
package mpif_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2,
    FWAIT = 2'd3
  } sched_state_e;

  // Ceiling log2, never below 1 so the result can always size a vector.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mpif_rr_arbiter.sv
// Purpose: combinational rotating-priority arbiter; searches upward from the
//          previous winner + 1 (mod NREQ) and returns the first requester set.
// Ports:
//   req_i   : per-requester request vector
//   last_i  : index of the previous winner
//   gnt_o   : one-hot winner (zero when no request)
//   idx_o   : index of the winner
//   valid_o : some requester won
module mpif_rr_arbiter
  import mpif_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]          req_i,
  input  logic [clog2(NREQ)-1:0]   last_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [clog2(NREQ)-1:0]   idx_o,
  output logic                     valid_o
);

  localparam int unsigned IDXW = clog2(NREQ);

  logic [IDXW-1:0] cand;

  // k = NREQ wraps back to last_i itself, so it has lowest priority.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDXW'((32'(last_i) + k) % NREQ);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpif_tx_fifo_scheduler.sv
// Purpose: round-robin scheduler sharing the MPIF transmit FIFO write port
//          between NREQ requesters, with write throttling on fifoFull and a
//          flush sequencer (flush pulse, then wait for null pointers).
// Ports:
//   clk, hardReset           : clock, synchronous active-high reset
//   req/reqLast/reqData      : per-requester word valid, packet-last, data
//   reqAck                   : word accepted this cycle (combinational)
//   grant                    : registered one-hot owner
//   fifoWrite/fifoWrData     : FIFO write port (combinational)
//   fifoFull/fifoPtrsNull    : FIFO status
//   flushReq                 : level flush request
//   fifoFlush                : flush to FIFO controller (registered)
//   flushDone/flushTimeout   : flush completion pulse / sticky timeout flag
module mpif_tx_fifo_scheduler
  import mpif_sched_pkg::*;
#(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned DATAWIDTH     = 32,
  parameter int unsigned MAXBURST      = 8,
  parameter int unsigned FLUSH_CYCLES  = 4,
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        hardReset,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0]             reqLast,
  input  logic [NREQ*DATAWIDTH-1:0]   reqData,
  output logic [NREQ-1:0]             reqAck,
  output logic [NREQ-1:0]             grant,
  output logic                        fifoWrite,
  output logic [DATAWIDTH-1:0]        fifoWrData,
  input  logic                        fifoFull,
  input  logic                        fifoPtrsNull,
  input  logic                        flushReq,
  output logic                        fifoFlush,
  output logic                        flushDone,
  output logic                        flushTimeout
);

  localparam int unsigned IDXW  = clog2(NREQ);
  localparam int unsigned BCW   = clog2(MAXBURST + 1);
  localparam int unsigned FCMAX = (FLUSH_TIMEOUT > FLUSH_CYCLES) ? FLUSH_TIMEOUT : FLUSH_CYCLES;
  localparam int unsigned FCW   = clog2(FCMAX + 1);

  sched_state_e    state_q;
  logic [NREQ-1:0] grant_q;
  logic [IDXW-1:0] gidx_q;
  logic [IDXW-1:0] last_q;
  logic [BCW-1:0]  burst_q;
  logic [FCW-1:0]  fcnt_q;
  logic            flush_q;
  logic            done_q;
  logic            tmo_q;

  logic [NREQ-1:0]      arb_gnt;
  logic [IDXW-1:0]      arb_idx;
  logic                 arb_valid;
  logic [DATAWIDTH-1:0] data_arr [NREQ];
  logic                 req_g;
  logic                 last_g;
  logic                 accept_c;
  logic                 burst_end_c;

  mpif_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req),
    .last_i  (last_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Unpack per-requester data words.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = reqData[i*DATAWIDTH +: DATAWIDTH];
  end

  assign req_g       = req[gidx_q];
  assign last_g      = reqLast[gidx_q];
  assign accept_c    = (state_q == XFER) && req_g && !fifoFull && !flushReq;
  assign burst_end_c = last_g || (burst_q == BCW'(MAXBURST - 1));

  assign fifoWrite    = accept_c;
  assign reqAck       = accept_c ? grant_q : '0;
  assign fifoWrData   = (|grant_q) ? data_arr[gidx_q] : '0;
  assign grant        = grant_q;
  assign fifoFlush    = flush_q;
  assign flushDone    = done_q;
  assign flushTimeout = tmo_q;

  // Scheduler state machine and registered outputs.
  always_ff @(posedge clk) begin
    if (hardReset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDXW'(NREQ - 1);
      burst_q <= '0;
      fcnt_q  <= '0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (flushReq) begin
            state_q <= FLUSH;
            flush_q <= 1'b1;
            fcnt_q  <= '0;
            tmo_q   <= 1'b0;
          end else if (arb_valid) begin
            state_q <= XFER;
            grant_q <= arb_gnt;
            gidx_q  <= arb_idx;
            burst_q <= '0;
          end
        end
        XFER: begin
          if (flushReq) begin
            // Abort the burst; flush always wins.
            state_q <= FLUSH;
            grant_q <= '0;
            last_q  <= gidx_q;
            flush_q <= 1'b1;
            fcnt_q  <= '0;
            tmo_q   <= 1'b0;
          end else if (!req_g) begin
            // Owner abandoned the burst.
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= gidx_q;
          end else if (accept_c) begin
            burst_q <= burst_q + BCW'(1);
            if (burst_end_c) begin
              state_q <= IDLE;
              grant_q <= '0;
              last_q  <= gidx_q;
            end
          end
        end
        FLUSH: begin
          tmo_q <= 1'b0;
          if (fcnt_q == FCW'(FLUSH_CYCLES - 1)) begin
            state_q <= FWAIT;
            flush_q <= 1'b0;
            fcnt_q  <= '0;
          end else begin
            fcnt_q <= fcnt_q + FCW'(1);
          end
        end
        FWAIT: begin
          if (fifoPtrsNull) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            fcnt_q  <= '0;
          end else if (fcnt_q == FCW'(FLUSH_TIMEOUT - 1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            tmo_q   <= 1'b1;
            fcnt_q  <= '0;
          end else begin
            fcnt_q <= fcnt_q + FCW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpif_tx_fifo_scheduler.sv
// Purpose: directed self-checking bench for mpif_tx_fifo_scheduler.
// Requester i presents word w as {8'hD0|i, 24'(w)}; a packet of lim[i] words
// (lim 0 = endless) is offered while want[i] is set.
module tb_mpif_tx_fifo_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 32;

  logic              clk;
  logic              hardReset;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   reqLast;
  logic [NREQ*DW-1:0] reqData;
  logic [NREQ-1:0]   reqAck;
  logic [NREQ-1:0]   grant;
  logic              fifoWrite;
  logic [DW-1:0]     fifoWrData;
  logic              fifoFull;
  logic              fifoPtrsNull;
  logic              flushReq;
  logic              fifoFlush;
  logic              flushDone;
  logic              flushTimeout;

  int nvec;
  int nerr;
  logic [NREQ-1:0] want;
  int lim  [NREQ];
  int wcnt [NREQ];

  mpif_tx_fifo_scheduler #(
    .NREQ(NREQ), .DATAWIDTH(DW), .MAXBURST(8), .FLUSH_CYCLES(4), .FLUSH_TIMEOUT(64)
  ) dut (
    .clk          (clk),
    .hardReset    (hardReset),
    .req          (req),
    .reqLast      (reqLast),
    .reqData      (reqData),
    .reqAck       (reqAck),
    .grant        (grant),
    .fifoWrite    (fifoWrite),
    .fifoWrData   (fifoWrData),
    .fifoFull     (fifoFull),
    .fifoPtrsNull (fifoPtrsNull),
    .flushReq     (flushReq),
    .fifoFlush    (fifoFlush),
    .flushDone    (flushDone),
    .flushTimeout (flushTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input int i, input int w);
    return {8'hD0 | 8'(i), 24'(w)};
  endfunction

  task automatic drive();
    logic [NREQ*DW-1:0] tmp;
    tmp = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      req[i]     = want[i] && (lim[i] == 0 || wcnt[i] < lim[i]);
      reqLast[i] = (lim[i] != 0) && (wcnt[i] == lim[i] - 1);
      tmp        = {tmp[(NREQ-1)*DW-1:0], word(i, wcnt[i])};
    end
    reqData = tmp;
  endtask

  task automatic pkt(input int i, input int len);
    want[i] = 1'b1;
    lim[i]  = len;
    wcnt[i] = 0;
    drive();
  endtask

  // One clock: acknowledged words advance, inputs re-driven, return at negedge.
  task automatic cyc();
    logic [NREQ-1:0] ack;
    ack = reqAck;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (ack[i]) wcnt[i]++;
    drive();
    @(negedge clk);
  endtask

  // From an IDLE arbitration cycle: expect a burst of n words from requester idx.
  task automatic expect_burst(input int idx, input int n, input int first);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_write", 32'(fifoWrite), 32'd0);
    cyc();
    for (int w = 0; w < n; w++) begin
      chk("burst_grant", 32'(grant), 32'(1 << idx));
      chk("burst_write", 32'(fifoWrite), 32'd1);
      chk("burst_ack", 32'(reqAck), 32'(1 << idx));
      chk("burst_data", fifoWrData, word(idx, first + w));
      cyc();
    end
    chk("burst_end_grant", 32'(grant), 32'd0);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    want = '0;
    for (int i = 0; i < NREQ; i++) begin lim[i] = 0; wcnt[i] = 0; end
    hardReset = 1'b1;
    fifoFull = 1'b0;
    fifoPtrsNull = 1'b0;
    flushReq = 1'b0;
    drive();
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_write", 32'(fifoWrite), 32'd0);
    chk("rst_ack", 32'(reqAck), 32'd0);
    chk("rst_flush", 32'(fifoFlush), 32'd0);
    chk("rst_done", 32'(flushDone), 32'd0);
    chk("rst_tmo", 32'(flushTimeout), 32'd0);
    chk("rst_wdata", fifoWrData, 32'd0);
    hardReset = 1'b0;

    // 1: two 3-word packets, requester 0 first, then 2; lastGrant=2 shown by 3 winning next.
    pkt(0, 3);
    pkt(2, 3);
    #1;
    expect_burst(0, 3, 0);
    expect_burst(2, 3, 0);
    pkt(0, 1);
    pkt(3, 1);
    #1;
    expect_burst(3, 1, 0);
    expect_burst(0, 1, 0);
    want = '0;
    drive();

    // 2: endless requester 1 is cut at 8 words, regranted alone, then yields to 2.
    pkt(1, 0);
    #1;
    expect_burst(1, 8, 0);
    expect_burst(1, 8, 8);
    pkt(2, 0);
    #1;
    expect_burst(2, 8, 0);
    want = '0;
    drive();
    cyc();

    // 3: fifoFull during burst cycles 3-6 of a 6-word packet.
    pkt(0, 6);
    #1;
    chk("full_idle_grant", 32'(grant), 32'd0);
    cyc();
    begin
      int w;
      w = 0;
      for (int c = 0; c < 10; c++) begin
        fifoFull = (c >= 2 && c <= 5);
        #1;
        chk("full_grant", 32'(grant), 32'b0001);
        chk("full_write", 32'(fifoWrite), 32'(!fifoFull));
        chk("full_ack", 32'(reqAck), fifoFull ? 32'd0 : 32'b0001);
        if (!fifoFull) begin
          chk("full_data", fifoWrData, word(0, w));
          w++;
        end
        cyc();
      end
    end
    fifoFull = 1'b0;
    #1;
    chk("full_end_grant", 32'(grant), 32'd0);
    chk("full_wordcount", 32'(wcnt[0]), 32'd6);
    want = '0;
    drive();

    // 4: flush aborts requester 1 at word 2; pointers go null 3 cycles after fifoFlush falls.
    pkt(1, 0);
    #1;
    cyc();
    chk("fl_grant", 32'(grant), 32'b0010);
    chk("fl_data0", fifoWrData, word(1, 0));
    cyc();
    flushReq = 1'b1;
    #1;
    chk("fl_abort_write", 32'(fifoWrite), 32'd0);
    chk("fl_abort_ack", 32'(reqAck), 32'd0);
    cyc();
    flushReq = 1'b0;
    #1;
    chk("fl_grant_clr", 32'(grant), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("fl_flush_hi", 32'(fifoFlush), 32'd1);
      chk("fl_no_write", 32'(fifoWrite), 32'd0);
      cyc();
    end
    chk("fl_flush_lo", 32'(fifoFlush), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("fl_wait_done", 32'(flushDone), 32'd0);
      cyc();
    end
    fifoPtrsNull = 1'b1;
    #1;
    chk("fl_pre_done", 32'(flushDone), 32'd0);
    cyc();
    fifoPtrsNull = 1'b0;
    chk("fl_done", 32'(flushDone), 32'd1);
    chk("fl_tmo", 32'(flushTimeout), 32'd0);
    cyc();
    chk("fl_done_pulse", 32'(flushDone), 32'd0);
    chk("fl_regrant", 32'(grant), 32'b0010);
    chk("fl_regrant_data", fifoWrData, word(1, 1));
    want = '0;
    drive();
    #1;
    chk("abandon_write", 32'(fifoWrite), 32'd0);
    cyc();
    chk("abandon_grant", 32'(grant), 32'd0);

    // 5: pointers never go null: timeout 64 cycles after fifoFlush falls.
    flushReq = 1'b1;
    #1;
    cyc();
    flushReq = 1'b0;
    chk("to_flush_hi", 32'(fifoFlush), 32'd1);
    repeat (4) cyc();
    chk("to_flush_lo", 32'(fifoFlush), 32'd0);
    begin
      int early;
      early = 0;
      for (int k = 0; k < 63; k++) begin
        cyc();
        if (flushDone) early++;
      end
      chk("to_no_early_done", 32'(early), 32'd0);
    end
    cyc();
    chk("to_done", 32'(flushDone), 32'd1);
    chk("to_tmo", 32'(flushTimeout), 32'd1);
    cyc();
    chk("to_done_pulse", 32'(flushDone), 32'd0);
    chk("to_tmo_sticky", 32'(flushTimeout), 32'd1);
    flushReq = 1'b1;
    #1;
    cyc();
    flushReq = 1'b0;
    chk("to_tmo_clr", 32'(flushTimeout), 32'd0);
    chk("to_reflush", 32'(fifoFlush), 32'd1);

    // 6: reset mid-flush, then mid-burst; requester 0 wins first afterwards.
    hardReset = 1'b1;
    cyc();
    hardReset = 1'b0;
    chk("rf_flush", 32'(fifoFlush), 32'd0);
    chk("rf_grant", 32'(grant), 32'd0);
    chk("rf_done", 32'(flushDone), 32'd0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
        cyc();
        if (flushDone || fifoFlush) seen++;
      end
      chk("rf_quiet", 32'(seen), 32'd0);
    end
    pkt(1, 0);
    #1;
    cyc();
    chk("rb_grant", 32'(grant), 32'b0010);
    chk("rb_write", 32'(fifoWrite), 32'd1);
    hardReset = 1'b1;
    cyc();
    hardReset = 1'b0;
    chk("rb_grant_clr", 32'(grant), 32'd0);
    chk("rb_write_clr", 32'(fifoWrite), 32'd0);
    chk("rb_done", 32'(flushDone), 32'd0);
    pkt(0, 0);
    #1;
    cyc();
    chk("rb_first_arb", 32'(grant), 32'b0001);
    chk("rb_first_data", fifoWrData, word(0, 0));
    want = '0;
    drive();
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
